aes_inv_cipher_iter: RTL and testbench



---
 rtl/aes_inv_cipher_iter.sv | 185 ++++++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, driven by 11 externally held round keys.
// key_s0 (round key 10) is applied first; key_s10 (the cipher key) finishes the final round.
module aes_inv_cipher_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key_s0,
    input  logic [127:0] key_s1,
    input  logic [127:0] key_s2,
    input  logic [127:0] key_s3,
    input  logic [127:0] key_s4,
    input  logic [127:0] key_s5,
    input  logic [127:0] key_s6,
    input  logic [127:0] key_s7,
    input  logic [127:0] key_s8,
    input  logic [127:0] key_s9,
    input  logic [127:0] key_s10,
    output logic         busy,
    output logic         done,
    output logic [127:0] plaintext
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } fsm_e;

    localparam logic [3:0] LAST_RND = 4'(NR);

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] state_q, state_d;
    logic [127:0] pt_q, pt_d;
    logic [127:0] rkey;
    logic [127:0] core;
    logic [127:0] mixed;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(x, x);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Inverse S-box: undo the affine map (rotl 1/3/6 ^ 0x05), then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    // InvShiftRows then InvSubBytes; byte n sits at row n%4, column n/4.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(4*c+row) -: 8] = inv_sbox(s[127-8*(4*((c-row+4)%4)+row) -: 8]);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a;
        logic [7:0]   x2, x4, x8;
        logic [7:0]   m9 [4];
        logic [7:0]   mb [4];
        logic [7:0]   md [4];
        logic [7:0]   me [4];
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                a     = s[127-8*(4*c+i) -: 8];
                x2    = xtime(a);
                x4    = xtime(x2);
                x8    = xtime(x4);
                m9[i] = x8 ^ a;
                mb[i] = x8 ^ x2 ^ a;
                md[i] = x8 ^ x4 ^ a;
                me[i] = x8 ^ x4 ^ x2;
            end
            for (int i = 0; i < 4; i++) begin
                r[127-8*(4*c+i) -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
            end
        end
        return r;
    endfunction

    always_comb begin
        case (rnd_q)
            4'd1:    rkey = key_s1;
            4'd2:    rkey = key_s2;
            4'd3:    rkey = key_s3;
            4'd4:    rkey = key_s4;
            4'd5:    rkey = key_s5;
            4'd6:    rkey = key_s6;
            4'd7:    rkey = key_s7;
            4'd8:    rkey = key_s8;
            4'd9:    rkey = key_s9;
            4'd10:   rkey = key_s10;
            default: rkey = key_s0;
        endcase
    end

    assign core  = inv_shift_sub(state_q) ^ rkey;
    assign mixed = inv_mix_columns(core);

    // FIN behaves like IDLE for acceptance so blocks can run back-to-back.
    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        pt_d    = pt_q;
        case (fsm_q)
            IDLE, FIN: begin
                fsm_d = IDLE;
                if (start) begin
                    state_d = ciphertext ^ key_s0;
                    rnd_d   = 4'd1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                if (rnd_q >= LAST_RND) begin
                    pt_d  = core;
                    rnd_d = 4'd0;
                    fsm_d = FIN;
                end else begin
                    state_d = mixed;
                    rnd_d   = rnd_q + 4'd1;
                end
            end
            default: begin
                fsm_d = IDLE;
                rnd_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            rnd_q   <= 4'd0;
            state_q <= '0;
            pt_q    <= '0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
            pt_q    <= pt_d;
        end
    end

    assign busy      = (fsm_q == RUN);
    assign done      = (fsm_q == FIN);
    assign plaintext = pt_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS-197 vectors, handshake corner cases, and random blocks
// whose ciphertext comes from a forward AES-128 reference (key expansion + encryption) kept here.
module tb_aes_inv_cipher_iter;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] ciphertext;
    logic [127:0] ks [0:10];
    logic         busy;
    logic         done;
    logic [127:0] plaintext;

    int n_asrt = 0;
    int n_fail = 0;
    int done_total = 0;

    logic [7:0]  sbox [256];
    logic [31:0] w [44];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    aes_inv_cipher_iter #(.NR(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ciphertext (ciphertext),
        .key_s0     (ks[0]),
        .key_s1     (ks[1]),
        .key_s2     (ks[2]),
        .key_s3     (ks[3]),
        .key_s4     (ks[4]),
        .key_s5     (ks[5]),
        .key_s6     (ks[6]),
        .key_s7     (ks[7]),
        .key_s8     (ks[8]),
        .key_s9     (ks[9]),
        .key_s10    (ks[10]),
        .busy       (busy),
        .done       (done),
        .plaintext  (plaintext)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_total <= done_total + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xt(p);
        end
        return acc;
    endfunction

    // Forward S-box: brute-force inverse search followed by the affine transform.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                      ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) ks[10-r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] rk;
        logic [127:0] out;
        rk = ks[10];
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c+row] = t[4*((c+row)%4)+row];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = mul(8'h02, a0) ^ mul(8'h03, a1) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ mul(8'h02, a1) ^ mul(8'h03, a2) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ mul(8'h02, a2) ^ mul(8'h03, a3);
                    s[4*c+3] = mul(8'h03, a0) ^ a1 ^ a2 ^ mul(8'h02, a3);
                end
            end
            rk = ks[10-r];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
        end
        out = '0;
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch at the next edge (E0), then wait up to 30 edges for done; leaves the bench in the done cycle.
    task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] exp_pt);
        int lat;
        int idle_seen;
        start      = 1'b1;
        ciphertext = ct;
        step();
        start      = 1'b0;
        ciphertext = {$urandom, $urandom, $urandom, $urandom};
        chk({tag, "_busy_start"}, 128'(busy), 128'd1);
        lat       = 0;
        idle_seen = 0;
        while (done !== 1'b1 && lat < 30) begin
            if (busy !== 1'b1) idle_seen++;
            step();
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'd10);
        chk({tag, "_busy_gap"}, 128'(idle_seen), 128'd0);
        chk({tag, "_pt"}, plaintext, exp_pt);
        chk({tag, "_busy_end"}, 128'(busy), 128'd0);
    endtask

    initial begin
        int base;
        logic [127:0] rkey, rpt, rct;
        rst        = 1'b1;
        start      = 1'b0;
        ciphertext = '0;
        for (int i = 0; i <= 10; i++) ks[i] = '0;
        build_sbox();

        // Reset state
        step();
        step();
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_pt", plaintext, 128'd0);
        chk("rst_state", dut.state_q, 128'd0);
        rst = 1'b0;
        step();

        // Reference model sanity against FIPS-197
        expand(C1_KEY);
        chk("model_c1_rk10", ks[0], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("model_c1_enc", encrypt(C1_PT), C1_CT);

        // C.1 with state probe after E0
        start      = 1'b1;
        ciphertext = C1_CT;
        step();
        start      = 1'b0;
        chk("c1_state_e0", dut.state_q, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
        chk("c1_busy_e0", 128'(busy), 128'd1);
        for (int i = 1; i < 10; i++) begin
            step();
            chk($sformatf("c1_busy_e%0d", i), {126'd0, busy, done}, 128'd2);
        end
        step();
        chk("c1_done_e10", 128'(done), 128'd1);
        chk("c1_pt", plaintext, C1_PT);
        step();
        chk("c1_done_pulse_len", 128'(done), 128'd0);
        chk("c1_pt_hold", plaintext, C1_PT);
        step();

        // Appendix B
        expand(B_KEY);
        chk("model_b_enc", encrypt(B_PT), B_CT);
        run_block("b", B_CT, B_PT);
        step();
        step();

        // Start pulsed while busy at rnd=5 is ignored
        expand(C1_KEY);
        base       = done_total;
        start      = 1'b1;
        ciphertext = C1_CT;
        step();
        start      = 1'b0;
        for (int i = 1; i <= 4; i++) step();
        chk("ign_rnd", 128'(dut.rnd_q), 128'd5);
        start      = 1'b1;
        ciphertext = B_CT;
        step();
        start      = 1'b0;
        for (int i = 6; i <= 10; i++) step();
        chk("ign_done", 128'(done), 128'd1);
        chk("ign_pt", plaintext, C1_PT);
        for (int i = 0; i < 14; i++) step();
        chk("ign_done_count", 128'(done_total - base), 128'd1);

        // Back-to-back: C.1 then B launched in the FIN cycle
        base = done_total;
        run_block("b2b_c1", C1_CT, C1_PT);
        expand(B_KEY);
        run_block("b2b_b", B_CT, B_PT);
        step();
        chk("b2b_done_count", 128'(done_total - base), 128'd2);
        step();

        // Asynchronous reset at rnd=4
        expand(C1_KEY);
        start      = 1'b1;
        ciphertext = C1_CT;
        step();
        start      = 1'b0;
        for (int i = 1; i <= 3; i++) step();
        chk("rst_mid_rnd", 128'(dut.rnd_q), 128'd4);
        base = done_total;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_busy", 128'(busy), 128'd0);
        chk("rst_mid_done", 128'(done), 128'd0);
        chk("rst_mid_pt", plaintext, 128'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("rst_mid_no_done", 128'(done_total - base), 128'd0);
        run_block("post_rst_c1", C1_CT, C1_PT);
        step();

        // Random keys and plaintexts, ciphertext from the forward model; alternate idle/back-to-back
        for (int n = 0; n < 8; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            rpt  = {$urandom, $urandom, $urandom, $urandom};
            expand(rkey);
            rct = encrypt(rpt);
            run_block($sformatf("rand%0d", n), rct, rpt);
            if (n % 2 == 1) begin
                for (int i = 0; i < int'($urandom_range(1, 3)); i++) step();
            end
        end
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
